// File: rtl/seq_or_monitor_if.sv
// rtl/seq_or_monitor_if.sv - stimulus/status bundle between a sequence monitor and its driver
interface seq_or_monitor_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             a;
  logic             b;
  logic             clr_stats;
  logic             busy;
  logic             pass;
  logic             fail;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output start, a, b, clr_stats,
    input  busy, pass, fail, pass_cnt, fail_cnt, drop_cnt
  );

  modport slave (
    input  start, a, b, clr_stats,
    output busy, pass, fail, pass_cnt, fail_cnt, drop_cnt
  );
endinterface

// File: rtl/seq_or_monitor.sv
// rtl/seq_or_monitor.sv - two-branch sequence checker with pass/fail pulses and saturating stats
module seq_or_monitor #(
  parameter int A_REPS = 2,
  parameter int B_LOW  = 3,
  parameter int B_HIGH = 2,
  parameter int MODE   = 0,
  parameter int CNT_W  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_or_monitor_if.slave mon
);
  localparam int L1   = A_REPS;
  localparam int L2   = B_LOW + B_HIGH;
  localparam int LMAX = (L1 > L2) ? L1 : L2;
  localparam int SW   = (LMAX > 1) ? $clog2(LMAX) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic pass;
    logic fail;
    logic pend1;
    logic pend2;
  } eval_t;

  // One attempt step: which pending branches complete or die, and whether that decides the attempt.
  function automatic eval_t eval_step(input int k, input logic av, input logic bv,
                                      input logic p1, input logic p2);
    eval_t r;
    logic  exp_b, done1, dead1, done2, dead2, n1, n2;
    done1 = p1 && av && (k == L1 - 1);
    dead1 = p1 && !av;
    exp_b = (k >= B_LOW);
    done2 = p2 && (bv == exp_b) && (k == L2 - 1);
    dead2 = p2 && (bv != exp_b);
    n1    = p1 && !done1 && !dead1;
    n2    = p2 && !done2 && !dead2;
    if (MODE == 0) begin
      r.pass = done1 || done2;
      r.fail = !r.pass && !n1 && !n2;
    end else begin
      r.fail = dead1 || dead2;
      r.pass = !r.fail && !n1 && !n2;
    end
    r.pend1 = n1;
    r.pend2 = n2;
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  state_t           state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic             pend1_q, pend1_d, pend2_q, pend2_d;
  logic             start_q;
  logic             busy_q, busy_d, pass_q, pass_d, fail_q, fail_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d, drop_cnt_q, drop_cnt_d;
  logic             rise, running, old_done, launch, new_done, drop;
  eval_t            cur, fresh;

  // Next state: finish the running attempt, and let a rise launch a new one at step 0 on the same edge.
  always_comb begin
    rise     = mon.start && !start_q;
    running  = (state_q == RUN);
    cur      = eval_step(int'(step_q), mon.a, mon.b, pend1_q, pend2_q);
    fresh    = eval_step(0, mon.a, mon.b, 1'b1, 1'b1);
    old_done = running && (cur.pass || cur.fail);
    launch   = rise && (!running || old_done);
    drop     = rise && running && !old_done;
    new_done = launch && (fresh.pass || fresh.fail);
    state_d  = state_q;
    step_d   = step_q;
    pend1_d  = pend1_q;
    pend2_d  = pend2_q;
    pass_d   = 1'b0;
    fail_d   = 1'b0;
    if (running) begin
      if (old_done) begin
        pass_d  = cur.pass;
        fail_d  = cur.fail;
        state_d = IDLE;
      end else begin
        step_d  = step_q + SW'(1);
        pend1_d = cur.pend1;
        pend2_d = cur.pend2;
      end
    end
    if (launch) begin
      if (new_done) begin
        // The older attempt owns the single pulse slot if both decide on this edge.
        if (!old_done) begin
          pass_d = fresh.pass;
          fail_d = fresh.fail;
        end
        state_d = IDLE;
      end else begin
        state_d = RUN;
        step_d  = SW'(1);
        pend1_d = fresh.pend1;
        pend2_d = fresh.pend2;
      end
    end
    busy_d     = (state_d == RUN);
    pass_cnt_d = mon.clr_stats ? '0 : sat_inc(pass_cnt_q, pass_d);
    fail_cnt_d = mon.clr_stats ? '0 : sat_inc(fail_cnt_q, fail_d);
    drop_cnt_d = mon.clr_stats ? '0 : sat_inc(drop_cnt_q, drop);
  end

  // Attempt FSM, registered pulses and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      step_q     <= '0;
      pend1_q    <= 1'b0;
      pend2_q    <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      pend1_q    <= pend1_d;
      pend2_q    <= pend2_d;
      start_q    <= mon.start;
      busy_q     <= busy_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign mon.busy     = busy_q;
  assign mon.pass     = pass_q;
  assign mon.fail     = fail_q;
  assign mon.pass_cnt = pass_cnt_q;
  assign mon.fail_cnt = fail_cnt_q;
  assign mon.drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_seq_or_monitor.sv
// tb/tb_seq_or_monitor.sv - scoreboard bench for seq_or_monitor in OR, AND and narrow-counter builds
module tb_seq_or_monitor;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] st;
  logic       a, b, clr;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  typedef struct {
    logic is_pass;
    int   cyc;
  } exp_t;

  exp_t q_or[$];
  exp_t q_and[$];
  exp_t q_c2[$];

  seq_or_monitor_if #(.CNT_W(8)) if_or ();
  seq_or_monitor_if #(.CNT_W(8)) if_and ();
  seq_or_monitor_if #(.CNT_W(2)) if_c2 ();

  assign if_or.start  = st[0];
  assign if_and.start = st[1];
  assign if_c2.start  = st[2];
  assign if_or.a = a;
  assign if_or.b = b;
  assign if_or.clr_stats = clr;
  assign if_and.a = a;
  assign if_and.b = b;
  assign if_and.clr_stats = clr;
  assign if_c2.a = a;
  assign if_c2.b = b;
  assign if_c2.clr_stats = clr;

  seq_or_monitor #(.MODE(0)) dut_or (.clk(clk), .rst_n(rst_n), .mon(if_or));
  seq_or_monitor #(.MODE(1)) dut_and (.clk(clk), .rst_n(rst_n), .mon(if_and));
  seq_or_monitor #(.MODE(0), .CNT_W(2)) dut_c2 (.clk(clk), .rst_n(rst_n), .mon(if_c2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int d, input logic is_pass, input int c);
    exp_t e;
    e.is_pass = is_pass;
    e.cyc = c;
    case (d)
      0: q_or.push_back(e);
      1: q_and.push_back(e);
      default: q_c2.push_back(e);
    endcase
  endtask

  task automatic mon_one(input int d, input string nm, input logic p, input logic f);
    exp_t e;
    logic have;
    have = 1'b0;
    if (p || f) begin
      chk({nm, "_excl"}, 32'(p && f), 0);
      case (d)
        0: if (q_or.size() > 0) begin e = q_or.pop_front(); have = 1'b1; end
        1: if (q_and.size() > 0) begin e = q_and.pop_front(); have = 1'b1; end
        default: if (q_c2.size() > 0) begin e = q_c2.pop_front(); have = 1'b1; end
      endcase
      if (!have) chk({nm, "_unexpected_pulse"}, 1, 0);
      else begin
        chk({nm, "_is_pass"}, 32'(p), 32'(e.is_pass));
        chk({nm, "_cycle"}, cyc, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_one(0, "or", if_or.pass, if_or.fail);
      mon_one(1, "and", if_and.pass, if_and.fail);
      mon_one(2, "c2", if_c2.pass, if_c2.fail);
    end
  end

  // Caller is at a negedge; bit k of each vector is the value for attempt step k.
  task automatic run_seq(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] sv,
                         input logic [7:0] cv, input logic [2:0] en, input int n,
                         input logic [7:0] bz, input logic chk_bz);
    for (int k = 0; k <= n; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (chk_bz) chk($sformatf("or_busy_step%0d", k - 1), 32'(if_or.busy), 32'(bz[k-1]));
      end
      if (k < n) begin
        a = av[k];
        b = bv[k];
        st = en & {3{sv[k]}};
        clr = cv[k];
      end else begin
        a = 1'b0;
        b = 1'b0;
        st = 3'b000;
        clr = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst_n = 1'b0;
    st = 3'b001;
    a = 1'b0;
    b = 1'b1;
    clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(if_or.busy), 0);
    chk("rst_pass", 32'(if_or.pass), 0);
    chk("rst_fail", 32'(if_or.fail), 0);
    chk("rst_pass_cnt", 32'(if_or.pass_cnt), 0);
    chk("rst_drop_cnt", 32'(if_and.drop_cnt), 0);

    // start already high when reset lifts: first edge is a rise, both branches die at step 0
    push(0, 1'b0, cyc + 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_edge_fail_cnt", 32'(if_or.fail_cnt), 1);
    chk("first_edge_busy", 32'(if_or.busy), 0);
    st = 3'b000;
    b = 1'b0;
    repeat (3) @(negedge clk);

    // reset in the middle of an attempt: abandoned silently, counters cleared
    st = 3'b001; a = 1'b1; b = 1'b0;
    @(negedge clk);
    a = 1'b0;
    @(negedge clk);
    chk("mid_busy_before_rst", 32'(if_or.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(if_or.busy), 0);
    chk("mid_rst_fail_cnt", 32'(if_or.fail_cnt), 0);
    @(negedge clk);
    st = 3'b000;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid_rst_no_pass", 32'(if_or.pass_cnt), 0);

    // scenario 1: OR passes on branch 1 at step 1, AND waits for branch 2 at step 4
    @(negedge clk); t0 = cyc + 1;
    push(0, 1'b1, t0 + 1);
    push(1, 1'b1, t0 + 4);
    run_seq(8'b00011, 8'b11000, 8'b00001, 8'b0, 3'b011, 5, 8'b0, 1'b0);
    chk("s1_or_pass_cnt", 32'(if_or.pass_cnt), 1);
    chk("s1_and_pass_cnt", 32'(if_and.pass_cnt), 1);

    // scenario 2: OR passes late on branch 2 with busy over steps 0-3; AND fails at step 1
    @(negedge clk); t0 = cyc + 1;
    push(0, 1'b1, t0 + 4);
    push(1, 1'b0, t0 + 1);
    run_seq(8'b00001, 8'b11000, 8'b00001, 8'b0, 3'b011, 5, 8'b01111, 1'b1);
    chk("s2_or_pass_cnt", 32'(if_or.pass_cnt), 2);
    chk("s2_and_fail_cnt", 32'(if_and.fail_cnt), 1);

    // scenario 3: branch 2 breaks at its last step -> fail at step 4
    @(negedge clk); t0 = cyc + 1;
    push(0, 1'b0, t0 + 4);
    run_seq(8'b00001, 8'b01000, 8'b00001, 8'b0, 3'b001, 5, 8'b01111, 1'b1);
    chk("s3_or_fail_cnt", 32'(if_or.fail_cnt), 1);

    // scenario 5: rise at step 2 is dropped; rise at deciding step 4 starts an attempt passing at its step 1
    @(negedge clk); t0 = cyc + 1;
    push(0, 1'b1, t0 + 4);
    push(0, 1'b1, t0 + 5);
    run_seq(8'b110001, 8'b011000, 8'b110101, 8'b0, 3'b001, 6, 8'b011111, 1'b1);
    chk("s5_or_drop_cnt", 32'(if_or.drop_cnt), 1);
    chk("s5_or_pass_cnt", 32'(if_or.pass_cnt), 4);

    // 2-bit counters saturate at 3
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); t0 = cyc + 1;
      push(2, 1'b1, t0 + 1);
      run_seq(8'b00011, 8'b11000, 8'b00001, 8'b0, 3'b100, 5, 8'b0, 1'b0);
    end
    chk("c2_pass_sat", 32'(if_c2.pass_cnt), 3);

    // clr_stats on the deciding edge beats the increment; the pulse itself still fires
    @(negedge clk); t0 = cyc + 1;
    push(0, 1'b1, t0 + 1);
    push(2, 1'b1, t0 + 1);
    run_seq(8'b00011, 8'b11000, 8'b00001, 8'b00010, 3'b101, 5, 8'b0, 1'b0);
    chk("clr_or_pass_cnt", 32'(if_or.pass_cnt), 0);
    chk("clr_or_fail_cnt", 32'(if_or.fail_cnt), 0);
    chk("clr_or_drop_cnt", 32'(if_or.drop_cnt), 0);
    chk("clr_c2_pass_cnt", 32'(if_c2.pass_cnt), 0);
    chk("clr_and_pass_cnt", 32'(if_and.pass_cnt), 0);

    repeat (4) @(negedge clk);
    chk("or_pending_expect", q_or.size(), 0);
    chk("and_pending_expect", q_and.size(), 0);
    chk("c2_pending_expect", q_c2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
